dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DSIZE, default 16, data word width.
REQ-002 Parameter ASIZE, default 10, word address width.
REQ-003 Clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 Enable  input  1  access request for the current cycle.
REQ-006 Write_Enab  input  1  1 = write, 0 = read; qualified by Enable.
REQ-007 Add_In  input  ASIZE  word address.
REQ-008 Data_in  input  DSIZE  write data.
REQ-009 Sw_in  input  16  asynchronous switch inputs.
REQ-010 Data_out  output  DSIZE  registered read data.
REQ-011 Led_out  output  16  LED register contents.
REQ-012 Irq_out  output  1  timer interrupt flag.

Function
REQ-013 Address map SHALL be:
- 0x000-0x3EF: RAM, 1008 words.
- 0x3F0: LED (R/W).
- 0x3F1: SW (RO).
- 0x3F2: CYC_LO (RO).
- 0x3F3: CYC_HI (RO).
- 0x3F4: TMR_RELOAD (R/W).
- 0x3F5: TMR_CTRL (R/W).
- 0x3F6: TMR_COUNT (RO).
- 0x3F7-0x3FF: reserved.
REQ-014 Read (Enable=1, Write_Enab=0) sampled at edge N SHALL present data on Data_out after edge N (latency 1 cycle).
REQ-015 Data_out SHALL hold its last value when Enable=0 and on write cycles.
REQ-016 Write (Enable=1, Write_Enab=1) at edge N SHALL update the target after edge N. Writes to RO or reserved addresses SHALL be ignored.
REQ-017 A read of an address in the same cycle as a write to it SHALL return the pre-write value.
REQ-018 Reserved reads SHALL return 0.
REQ-019 SW reads SHALL return Sw_in through a two-flop synchronizer.
REQ-020 The 32-bit cycle counter SHALL increment every cycle and wrap from 0xFFFFFFFF to 0.
REQ-021 A CYC_LO read SHALL return bits [15:0] and latch bits [31:16] in the same cycle. A later CYC_HI read SHALL return the latched value.
REQ-022 TMR_CTRL bits SHALL be:
- bit0 EN.
- bit1 AUTO.
- bit2 FLAG: read returns the flag; writing 1 clears it.
- bits [15:3]: read 0.
REQ-023 A TMR_RELOAD write SHALL also load TMR_COUNT with the written value.
REQ-024 Writing TMR_CTRL with EN rising from 0 to 1 SHALL load TMR_COUNT from TMR_RELOAD.
REQ-025 While EN=1 and TMR_COUNT>0, TMR_COUNT SHALL decrement by 1 per cycle.
REQ-026 While EN=1 and TMR_COUNT=0 (expiry), FLAG SHALL be set. Then:
- AUTO=1: TMR_COUNT SHALL reload from TMR_RELOAD.
- AUTO=0: EN SHALL clear.
REQ-027 If expiry and a FLAG-clear write occur in the same cycle, FLAG SHALL remain 1.
REQ-028 If expiry and a TMR_RELOAD write occur in the same cycle, TMR_COUNT SHALL take the written value.
REQ-029 Irq_out SHALL equal FLAG.
REQ-030 With Enable=0, Write_Enab and Data_in SHALL have no effect.

Reset
REQ-031 Rst=1 at an edge SHALL clear the following to 0: Data_out, Led_out, Irq_out, cycle counter, HI latch, TMR_RELOAD, TMR_COUNT, TMR_CTRL, synchronizer flops.
REQ-032 Reset SHALL take priority over any access in the same cycle. RAM contents SHALL NOT be cleared.
REQ-033 Reset asserted mid-countdown SHALL stop the timer, with Irq_out=0 on the next cycle.

Verification
REQ-034 Write 0x1234 to 0x005, then read 0x005 -> Data_out=0x1234 one cycle after the read edge; it holds through following idle cycles.
REQ-035 Read and write 0x005 (holding 0x1234) with 0xBEEF in the same cycle -> read returns 0x1234; a subsequent read returns 0xBEEF.
REQ-036 Write TMR_RELOAD=3, TMR_CTRL=0x1 -> Irq_out rises 4 cycles after the CTRL write edge; EN reads back 0; a 0x4 write clears Irq_out.
REQ-037 Reload=2 with AUTO=1 -> FLAG sets on expiry and TMR_COUNT sequence 2,1,0,2,1,0 repeats; a clear write on an expiry cycle leaves Irq_out=1.
REQ-038 Hold the cycle counter across 0x0000FFFF->0x00010000 while reading CYC_LO at count 0x0000FFFF and CYC_HI later -> reads 0xFFFF then 0x0000; reserved 0x3FA reads 0; writes to 0x3F1 and 0x3F6 are ignored.
REQ-039 Assert Rst during an active countdown with Led_out=0xA5A5 -> all outputs 0 next cycle; previously written RAM data still reads back.

Source files
------------

// File: rtl/dmem_resp.sv
// Data memory with memory-mapped LED, switch, free-running cycle counter and
// countdown timer peripherals; single-cycle registered read response.
`timescale 1ns/1ps
module dmem_resp #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 10
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             Write_Enab,
    input  logic [ASIZE-1:0] Add_In,
    input  logic [DSIZE-1:0] Data_in,
    input  logic [15:0]      Sw_in,
    output logic [DSIZE-1:0] Data_out,
    output logic [15:0]      Led_out,
    output logic             Irq_out
);

    localparam int RAM_WORDS = 1008;

    localparam logic [ASIZE-1:0] A_LED    = ASIZE'(10'h3F0);
    localparam logic [ASIZE-1:0] A_SW     = ASIZE'(10'h3F1);
    localparam logic [ASIZE-1:0] A_CYCLO  = ASIZE'(10'h3F2);
    localparam logic [ASIZE-1:0] A_CYCHI  = ASIZE'(10'h3F3);
    localparam logic [ASIZE-1:0] A_RELOAD = ASIZE'(10'h3F4);
    localparam logic [ASIZE-1:0] A_CTRL   = ASIZE'(10'h3F5);
    localparam logic [ASIZE-1:0] A_COUNT  = ASIZE'(10'h3F6);

    logic             rdEn;
    logic             wrEn;
    logic             isRam;
    logic [15:0]      wr16;

    logic [DSIZE-1:0] mem_q [RAM_WORDS];
    logic [DSIZE-1:0] rdData;

    logic [DSIZE-1:0] dataOut_q,   dataOut_d;
    logic [15:0]      led_q,       led_d;
    logic [15:0]      swMeta_q,    swSync_q;
    logic [31:0]      cycCnt_q,    cycCnt_d;
    logic [15:0]      hiLatch_q,   hiLatch_d;
    logic [15:0]      tmrReload_q, tmrReload_d;
    logic [15:0]      tmrCount_q,  tmrCount_d;
    logic             tmrEn_q,     tmrEn_d;
    logic             tmrAuto_q,   tmrAuto_d;
    logic             tmrFlag_q,   tmrFlag_d;
    logic             expiry;

    assign rdEn  = Enable & ~Write_Enab;
    assign wrEn  = Enable & Write_Enab;
    assign isRam = (Add_In < ASIZE'(RAM_WORDS));
    assign wr16  = 16'(Data_in);

    // RAM is deliberately left out of reset; reset still blocks a same-cycle write.
    always_ff @(posedge Clk) begin
        if (!Rst && wrEn && isRam) begin
            mem_q[Add_In] <= Data_in;
        end
    end

    always_comb begin
        rdData = '0;
        if (isRam) begin
            rdData = mem_q[Add_In];
        end else begin
            case (Add_In)
                A_LED:    rdData = DSIZE'(led_q);
                A_SW:     rdData = DSIZE'(swSync_q);
                A_CYCLO:  rdData = DSIZE'(cycCnt_q[15:0]);
                A_CYCHI:  rdData = DSIZE'(hiLatch_q);
                A_RELOAD: rdData = DSIZE'(tmrReload_q);
                A_CTRL:   rdData = DSIZE'({13'b0, tmrFlag_q, tmrAuto_q, tmrEn_q});
                A_COUNT:  rdData = DSIZE'(tmrCount_q);
                default:  rdData = '0;
            endcase
        end
    end

    assign expiry = tmrEn_q && (tmrCount_q == 16'd0);

    // Timer runs first; register writes then override, except a FLAG clear never beats expiry.
    always_comb begin
        dataOut_d   = rdEn ? rdData : dataOut_q;
        led_d       = led_q;
        cycCnt_d    = cycCnt_q + 32'd1;
        hiLatch_d   = hiLatch_q;
        tmrReload_d = tmrReload_q;
        tmrCount_d  = tmrCount_q;
        tmrEn_d     = tmrEn_q;
        tmrAuto_d   = tmrAuto_q;
        tmrFlag_d   = tmrFlag_q;

        if (rdEn && Add_In == A_CYCLO) begin
            hiLatch_d = cycCnt_q[31:16];
        end

        if (tmrEn_q) begin
            if (tmrCount_q != 16'd0) begin
                tmrCount_d = tmrCount_q - 16'd1;
            end else begin
                tmrFlag_d = 1'b1;
                if (tmrAuto_q) begin
                    tmrCount_d = tmrReload_q;
                end else begin
                    tmrEn_d = 1'b0;
                end
            end
        end

        if (wrEn) begin
            case (Add_In)
                A_LED: led_d = wr16;
                A_RELOAD: begin
                    tmrReload_d = wr16;
                    tmrCount_d  = wr16;
                end
                A_CTRL: begin
                    tmrEn_d   = wr16[0];
                    tmrAuto_d = wr16[1];
                    if (wr16[2] && !expiry) begin
                        tmrFlag_d = 1'b0;
                    end
                    if (wr16[0] && !tmrEn_q) begin
                        tmrCount_d = tmrReload_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dataOut_q   <= '0;
            led_q       <= '0;
            swMeta_q    <= '0;
            swSync_q    <= '0;
            cycCnt_q    <= '0;
            hiLatch_q   <= '0;
            tmrReload_q <= '0;
            tmrCount_q  <= '0;
            tmrEn_q     <= 1'b0;
            tmrAuto_q   <= 1'b0;
            tmrFlag_q   <= 1'b0;
        end else begin
            dataOut_q   <= dataOut_d;
            led_q       <= led_d;
            swMeta_q    <= Sw_in;
            swSync_q    <= swMeta_q;
            cycCnt_q    <= cycCnt_d;
            hiLatch_q   <= hiLatch_d;
            tmrReload_q <= tmrReload_d;
            tmrCount_q  <= tmrCount_d;
            tmrEn_q     <= tmrEn_d;
            tmrAuto_q   <= tmrAuto_d;
            tmrFlag_q   <= tmrFlag_d;
        end
    end

    assign Data_out = dataOut_q;
    assign Led_out  = led_q;
    assign Irq_out  = tmrFlag_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp: RAM, peripherals, timer and reset.
`timescale 1ns/1ps
module tb_dmem_resp;

    logic        Clk;
    logic        Rst;
    logic        Enable;
    logic        Write_Enab;
    logic [9:0]  Add_In;
    logic [15:0] Data_in;
    logic [15:0] Sw_in;
    logic [15:0] Data_out;
    logic [15:0] Led_out;
    logic        Irq_out;

    int          checkCount;
    int          passCount;
    logic [31:0] cycCount;
    logic [31:0] cycSnap;
    int          seq [6];

    dmem_resp #(.DSIZE(16), .ASIZE(10)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Enable    (Enable),
        .Write_Enab(Write_Enab),
        .Add_In    (Add_In),
        .Data_in   (Data_in),
        .Sw_in     (Sw_in),
        .Data_out  (Data_out),
        .Led_out   (Led_out),
        .Irq_out   (Irq_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // One call = one rising edge; outputs are stable 1ns after it.
    task automatic applyStimulus(input logic en, input logic we, input logic [9:0] addr, input logic [15:0] data);
        Enable     = en;
        Write_Enab = we;
        Add_In     = addr;
        Data_in    = data;
        @(posedge Clk);
        #1;
        if (Rst) cycCount = 32'd0;
        else     cycCount = cycCount + 32'd1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b1, 10'h005, 16'hFFFF);
    endtask

    task automatic doReset(input logic en, input logic we, input logic [9:0] addr, input logic [15:0] data);
        Rst = 1'b1;
        applyStimulus(en, we, addr, data);
        Rst = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        cycCount   = 32'd0;
        Rst        = 1'b0;
        Enable     = 1'b0;
        Write_Enab = 1'b0;
        Add_In     = '0;
        Data_in    = '0;
        Sw_in      = 16'h5A5A;
        seq        = '{2, 1, 0, 2, 1, 0};
        @(negedge Clk);

        doReset(1'b0, 1'b0, 10'h000, 16'h0000);
        checkOutput("reset_dout", 32'(Data_out), 32'h0);
        checkOutput("reset_led",  32'(Led_out),  32'h0);
        checkOutput("reset_irq",  32'(Irq_out),  32'h0);

        // RAM write, registered read, hold through idles (idles drive WE/data with Enable low)
        applyStimulus(1'b1, 1'b1, 10'h005, 16'h1234);
        checkOutput("write_holds_dout", 32'(Data_out), 32'h0);
        applyStimulus(1'b1, 1'b0, 10'h005, 16'h0000);
        checkOutput("ram_read", 32'(Data_out), 32'h1234);
        idle();
        idle();
        checkOutput("ram_hold", 32'(Data_out), 32'h1234);

        applyStimulus(1'b1, 1'b1, 10'h005, 16'hBEEF);
        checkOutput("wr_keeps_old", 32'(Data_out), 32'h1234);
        applyStimulus(1'b1, 1'b0, 10'h005, 16'h0000);
        checkOutput("ram_new", 32'(Data_out), 32'hBEEF);

        applyStimulus(1'b1, 1'b1, 10'h3F0, 16'hA5A5);
        checkOutput("led_out", 32'(Led_out), 32'hA5A5);
        applyStimulus(1'b1, 1'b0, 10'h3F0, 16'h0000);
        checkOutput("led_read", 32'(Data_out), 32'hA5A5);

        applyStimulus(1'b1, 1'b1, 10'h3F1, 16'h1111);
        applyStimulus(1'b1, 1'b0, 10'h3F1, 16'h0000);
        checkOutput("sw_read_ro", 32'(Data_out), 32'h5A5A);
        applyStimulus(1'b1, 1'b0, 10'h3FA, 16'h0000);
        checkOutput("reserved_read", 32'(Data_out), 32'h0);

        // One-shot timer: reload 3, irq rises 4 edges after the enabling write
        applyStimulus(1'b1, 1'b1, 10'h3F4, 16'h0003);
        applyStimulus(1'b1, 1'b1, 10'h3F5, 16'h0001);
        idle();
        idle();
        idle();
        checkOutput("oneshot_irq_early", 32'(Irq_out), 32'h0);
        idle();
        checkOutput("oneshot_irq_rise", 32'(Irq_out), 32'h1);
        applyStimulus(1'b1, 1'b0, 10'h3F5, 16'h0000);
        checkOutput("oneshot_ctrl", 32'(Data_out), 32'h0004);
        applyStimulus(1'b1, 1'b0, 10'h3F4, 16'h0000);
        checkOutput("reload_read", 32'(Data_out), 32'h0003);
        applyStimulus(1'b1, 1'b1, 10'h3F6, 16'h0055);
        applyStimulus(1'b1, 1'b0, 10'h3F6, 16'h0000);
        checkOutput("count_ro", 32'(Data_out), 32'h0);
        applyStimulus(1'b1, 1'b1, 10'h3F5, 16'h0004);
        checkOutput("oneshot_clear", 32'(Irq_out), 32'h0);

        // Auto-reload timer with reload 2
        applyStimulus(1'b1, 1'b1, 10'h3F4, 16'h0002);
        applyStimulus(1'b1, 1'b1, 10'h3F5, 16'h0003);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 10'h3F6, 16'h0000);
            checkOutput($sformatf("auto_count%0d", i), 32'(Data_out), 32'(seq[i]));
            if (i == 2) checkOutput("auto_irq", 32'(Irq_out), 32'h1);
        end
        applyStimulus(1'b1, 1'b1, 10'h3F5, 16'h0007);
        checkOutput("auto_clear", 32'(Irq_out), 32'h0);
        idle();
        applyStimulus(1'b1, 1'b1, 10'h3F5, 16'h0007);
        checkOutput("clear_on_expiry", 32'(Irq_out), 32'h1);
        applyStimulus(1'b1, 1'b0, 10'h3F6, 16'h0000);
        checkOutput("auto_reloaded", 32'(Data_out), 32'h2);
        applyStimulus(1'b1, 1'b1, 10'h3F5, 16'h0004);
        checkOutput("auto_stop", 32'(Irq_out), 32'h0);

        // Cycle counter across the 16-bit boundary
        for (int guard = 0; guard < 70000 && cycCount != 32'h0000FFFF; guard++) idle();
        checkOutput("cyc_reached", cycCount, 32'h0000FFFF);
        applyStimulus(1'b1, 1'b0, 10'h3F2, 16'h0000);
        checkOutput("cyc_lo_ffff", 32'(Data_out), 32'hFFFF);
        idle();
        idle();
        applyStimulus(1'b1, 1'b0, 10'h3F3, 16'h0000);
        checkOutput("cyc_hi_latched", 32'(Data_out), 32'h0000);
        cycSnap = cycCount;
        applyStimulus(1'b1, 1'b0, 10'h3F2, 16'h0000);
        checkOutput("cyc_lo_model", 32'(Data_out), {16'h0, cycSnap[15:0]});
        applyStimulus(1'b1, 1'b0, 10'h3F3, 16'h0000);
        checkOutput("cyc_hi_model", 32'(Data_out), {16'h0, cycSnap[31:16]});

        // Reset in the middle of an auto-reload countdown with the flag set
        applyStimulus(1'b1, 1'b0, 10'h3F0, 16'h0000);
        checkOutput("pre_rst_led", 32'(Data_out), 32'hA5A5);
        applyStimulus(1'b1, 1'b1, 10'h3F4, 16'h0002);
        applyStimulus(1'b1, 1'b1, 10'h3F5, 16'h0003);
        idle();
        idle();
        idle();
        idle();
        checkOutput("pre_rst_irq", 32'(Irq_out), 32'h1);
        doReset(1'b1, 1'b1, 10'h3F0, 16'hFFFF);
        checkOutput("rst_dout", 32'(Data_out), 32'h0);
        checkOutput("rst_led",  32'(Led_out),  32'h0);
        checkOutput("rst_irq",  32'(Irq_out),  32'h0);
        for (int i = 0; i < 5; i++) idle();
        checkOutput("rst_timer_stopped", 32'(Irq_out), 32'h0);
        applyStimulus(1'b1, 1'b0, 10'h3F5, 16'h0000);
        checkOutput("rst_ctrl", 32'(Data_out), 32'h0);
        applyStimulus(1'b1, 1'b0, 10'h005, 16'h0000);
        checkOutput("rst_ram_kept", 32'(Data_out), 32'hBEEF);
        applyStimulus(1'b1, 1'b0, 10'h3F6, 16'h0000);
        checkOutput("rst_count", 32'(Data_out), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
